// File: rtl/pong_pkg.sv
// Shared Pong constants: FSM/winner encodings and screen/paddle geometry.
// Used by the game controller, the renderer and the paddle controller.
package pong_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned BALL_SIZE    = 20;
  localparam int unsigned P1_X         = 30;
  localparam int unsigned P2_X         = 600;
  localparam int unsigned PADDLE_W     = 10;
  localparam int unsigned PADDLE_H     = 100;
  localparam int unsigned GOAL_L       = 25;
  localparam int unsigned GOAL_R       = 610;
  localparam int unsigned WIN_SCORE    = 9;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned HIT_HOLDOFF  = 8;

  // All geometry compares run at 11 bits so x+BALL_SIZE never wraps.
  function automatic logic [10:0] c11(input int unsigned v);
    return v[10:0];
  endfunction

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Frame-rate bundle between the game controller and the VGA/ball stage.
// master = ball/render side, slave = game controller.
interface pong_game_ctrl_if;

  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [8:0] p1_y;
  logic [8:0] p2_y;
  logic       h_col;
  logic       v_col;
  logic       ball_enable;
  logic       ball_restart;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [1:0] state;

  modport master (
    output frame_tick, start, ball_x, ball_y, p1_y, p2_y,
    input  h_col, v_col, ball_enable, ball_restart, serve_dir,
    input  p1_score, p2_score, winner, state
  );

  modport slave (
    input  frame_tick, start, ball_x, ball_y, p1_y, p2_y,
    output h_col, v_col, ball_enable, ball_restart, serve_dir,
    output p1_score, p2_score, winner, state
  );

endinterface

// File: rtl/pong_hit_detect.sv
// Box-overlap test between the ball and one paddle.
// RIGHT selects the ball's right edge for the x test (right paddle).
import pong_pkg::*;

module pong_hit_detect #(
  parameter int unsigned PAD_X = P1_X,
  parameter bit          RIGHT = 1'b0
) (
  input  logic [9:0] i_ball_x,
  input  logic [8:0] i_ball_y,
  input  logic [8:0] i_pad_y,
  output logic       o_hit
);

  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic [10:0] w_py;
  logic        w_x_ok;
  logic        w_y_ok;

  assign w_bx = RIGHT ? ext11(i_ball_x) + c11(BALL_SIZE)
                      : ext11(i_ball_x);
  assign w_by = {2'b00, i_ball_y};
  assign w_py = {2'b00, i_pad_y};

  assign w_x_ok = (w_bx >= c11(PAD_X)) &&
                  (w_bx <= c11(PAD_X + PADDLE_W));
  assign w_y_ok = (w_by + c11(BALL_SIZE) >= w_py) &&
                  (w_by <= w_py + c11(PADDLE_H));

  assign o_hit = w_x_ok && w_y_ok;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-sampled Pong game FSM: paddle/wall collisions, goals, scores,
// serve hold-off and game-over handling.
import pong_pkg::*;

module pong_game_ctrl (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [3:0] WIN4    = 4'(WIN_SCORE);
  localparam logic [3:0] HOLD4   = 4'(HIT_HOLDOFF);
  localparam logic [5:0] FR_LAST = 6'(SERVE_FRAMES - 1);

  logic [1:0] r_state;
  logic       r_h_col;
  logic       r_v_col;
  logic       r_restart;
  logic       r_serve_dir;
  logic [3:0] r_p1;
  logic [3:0] r_p2;
  logic [1:0] r_winner;
  logic [3:0] r_hold;
  logic [5:0] r_frames;

  logic       w_hit1;
  logic       w_hit2;
  logic       w_hit;
  logic       w_wall;
  logic       w_goal_l;
  logic       w_goal_r;
  logic [3:0] w_p1_nx;
  logic [3:0] w_p2_nx;

  pong_hit_detect #(.PAD_X(P1_X), .RIGHT(1'b0)) u_hit_p1 (
    .i_ball_x (bus.ball_x),
    .i_ball_y (bus.ball_y),
    .i_pad_y  (bus.p1_y),
    .o_hit    (w_hit1)
  );

  pong_hit_detect #(.PAD_X(P2_X), .RIGHT(1'b1)) u_hit_p2 (
    .i_ball_x (bus.ball_x),
    .i_ball_y (bus.ball_y),
    .i_pad_y  (bus.p2_y),
    .o_hit    (w_hit2)
  );

  assign w_hit    = (w_hit1 || w_hit2) && (r_hold == 4'd0);
  assign w_wall   = (bus.ball_y == 9'd0) ||
                    ({2'b00, bus.ball_y} >= c11(SCREEN_H - BALL_SIZE));
  assign w_goal_l = ext11(bus.ball_x) < c11(GOAL_L);
  assign w_goal_r = ext11(bus.ball_x) + c11(BALL_SIZE) > c11(GOAL_R);
  assign w_p1_nx  = r_p1 + 4'd1;
  assign w_p2_nx  = r_p2 + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_h_col     <= 1'b0;
      r_v_col     <= 1'b0;
      r_restart   <= 1'b0;
      r_serve_dir <= 1'b0;
      r_p1        <= 4'd0;
      r_p2        <= 4'd0;
      r_winner    <= WIN_NONE;
      r_hold      <= 4'd0;
      r_frames    <= 6'd0;
    end else begin
      r_h_col   <= 1'b0;
      r_v_col   <= 1'b0;
      r_restart <= 1'b0;
      if (bus.frame_tick && r_hold != 4'd0)
        r_hold <= r_hold - 4'd1;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_PLAY;
            r_restart <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (bus.frame_tick) begin
            // one action per frame, highest priority first
            if (w_hit) begin
              r_h_col <= 1'b1;
              r_hold  <= HOLD4;
            end else if (w_wall) begin
              r_v_col <= 1'b1;
            end else if (w_goal_l) begin
              r_p2        <= w_p2_nx;
              r_serve_dir <= 1'b0;
              if (w_p2_nx == WIN4) begin
                r_state  <= ST_OVER;
                r_winner <= WIN_P2;
              end else begin
                r_state   <= ST_POINT;
                r_restart <= 1'b1;
                r_frames  <= 6'd0;
              end
            end else if (w_goal_r) begin
              r_p1        <= w_p1_nx;
              r_serve_dir <= 1'b1;
              if (w_p1_nx == WIN4) begin
                r_state  <= ST_OVER;
                r_winner <= WIN_P1;
              end else begin
                r_state   <= ST_POINT;
                r_restart <= 1'b1;
                r_frames  <= 6'd0;
              end
            end
          end
        end
        ST_POINT: begin
          if (bus.frame_tick) begin
            if (r_frames == FR_LAST) begin
              r_state  <= ST_PLAY;
              r_frames <= 6'd0;
            end else begin
              r_frames <= r_frames + 6'd1;
            end
          end
        end
        ST_OVER: begin
          if (bus.start) begin
            r_p1      <= 4'd0;
            r_p2      <= 4'd0;
            r_winner  <= WIN_NONE;
            r_restart <= 1'b1;
            r_state   <= ST_PLAY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.h_col        = r_h_col;
  assign bus.v_col        = r_v_col;
  assign bus.ball_restart = r_restart;
  assign bus.ball_enable  = (r_state == ST_PLAY);
  assign bus.serve_dir    = r_serve_dir;
  assign bus.p1_score     = r_p1;
  assign bus.p2_score     = r_p2;
  assign bus.winner       = r_winner;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: hits, hold-off, walls, goals,
// serve delay, game over/restart and reset behaviour.
module tb_pong_game_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pong_game_ctrl_if bus ();

  pong_game_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_frame();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start  = 1'b0;
    bus.ball_x = 10'd300;
    bus.ball_y = 9'd200;
    bus.p1_y   = 9'd100;
    bus.p2_y   = 9'd100;
    repeat (3) @(negedge clk);

    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_en", 32'(bus.ball_enable), 32'd0);
    chk("rst_p1", 32'(bus.p1_score), 32'd0);
    chk("rst_p2", 32'(bus.p2_score), 32'd0);
    chk("rst_win", 32'(bus.winner), 32'd0);
    chk("rst_dir", 32'(bus.serve_dir), 32'd0);
    chk("rst_pulses",
        32'({bus.h_col, bus.v_col, bus.ball_restart}), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 32'(bus.state), 32'd0);
    pulse_start();
    chk("start_state", 32'(bus.state), 32'd1);
    chk("start_restart", 32'(bus.ball_restart), 32'd1);
    chk("start_en", 32'(bus.ball_enable), 32'd1);
    @(negedge clk);
    chk("restart_1cyc", 32'(bus.ball_restart), 32'd0);
    chk("start_scores", 32'({bus.p1_score, bus.p2_score}), 32'd0);

    // paddle hit, then 8 frames of hold-off
    bus.ball_x = 10'd35;
    bus.ball_y = 9'd150;
    bus.p1_y   = 9'd100;
    tick_frame();
    chk("hit1", 32'({bus.h_col, bus.v_col}), 32'b10);
    @(negedge clk);
    chk("hit1_1cyc", 32'(bus.h_col), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick_frame();
      chk("holdoff", 32'(bus.h_col), 32'd0);
    end
    tick_frame();
    chk("hit_again", 32'(bus.h_col), 32'd1);

    // bottom wall
    bus.ball_x = 10'd300;
    bus.ball_y = 9'd460;
    tick_frame();
    chk("wall_v", 32'({bus.h_col, bus.v_col}), 32'b01);
    chk("wall_scores", 32'({bus.p1_score, bus.p2_score}), 32'd0);
    bus.ball_y = 9'd459;
    tick_frame();
    chk("no_wall_459", 32'(bus.v_col), 32'd0);

    // left goal held over several frames
    bus.ball_x = 10'd20;
    bus.ball_y = 9'd200;
    tick_frame();
    chk("goal_l_p2", 32'(bus.p2_score), 32'd1);
    chk("goal_l_state", 32'(bus.state), 32'd2);
    chk("goal_l_dir", 32'(bus.serve_dir), 32'd0);
    chk("goal_l_restart", 32'(bus.ball_restart), 32'd1);
    chk("goal_l_en", 32'(bus.ball_enable), 32'd0);
    tick_frame();
    tick_frame();
    chk("goal_once", 32'(bus.p2_score), 32'd1);
    bus.start = 1'b1;
    for (int i = 2; i < 59; i++) tick_frame();
    bus.start = 1'b0;
    chk("point_59", 32'(bus.state), 32'd2);
    tick_frame();
    chk("point_60", 32'(bus.state), 32'd1);

    // paddle and top wall in the same frame
    bus.ball_x = 10'd35;
    bus.ball_y = 9'd0;
    bus.p1_y   = 9'd0;
    tick_frame();
    chk("hit_over_wall", 32'({bus.h_col, bus.v_col}), 32'b10);

    // eight right goals, each followed by the serve delay
    bus.ball_y = 9'd200;
    bus.p1_y   = 9'd100;
    for (int k = 1; k <= 8; k++) begin
      bus.ball_x = 10'd600;
      tick_frame();
      chk("goal_r_p1", 32'(bus.p1_score), 32'(k));
      chk("goal_r_dir", 32'(bus.serve_dir), 32'd1);
      bus.ball_x = 10'd300;
      repeat (60) tick_frame();
      chk("serve_back", 32'(bus.state), 32'd1);
    end
    bus.ball_x = 10'd600;
    tick_frame();
    chk("win_p1", 32'(bus.p1_score), 32'd9);
    chk("win_code", 32'(bus.winner), 32'b01);
    chk("win_state", 32'(bus.state), 32'd3);
    tick_frame();
    chk("over_hold_p1", 32'(bus.p1_score), 32'd9);
    chk("over_hold_p2", 32'(bus.p2_score), 32'd1);
    chk("over_en", 32'(bus.ball_enable), 32'd0);
    bus.ball_x = 10'd300;
    pulse_start();
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_pulse", 32'(bus.ball_restart), 32'd1);
    chk("restart_scores", 32'({bus.p1_score, bus.p2_score}), 32'd0);
    chk("restart_win", 32'(bus.winner), 32'd0);

    // reset drops an in-flight h_col pulse
    bus.ball_x = 10'd35;
    bus.ball_y = 9'd150;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    chk("inflight_hcol", 32'(bus.h_col), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hcol", 32'(bus.h_col), 32'd0);
    chk("midrst_state", 32'(bus.state), 32'd0);

    // start and frame_tick together in IDLE: no collision that frame
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    chk("idle_tick_state", 32'(bus.state), 32'd1);
    chk("idle_tick_hcol", 32'(bus.h_col), 32'd0);
    chk("idle_tick_rst", 32'(bus.ball_restart), 32'd1);
    tick_frame();
    chk("after_idle_hit", 32'(bus.h_col), 32'd1);

    // right paddle edge case: ball_x+20 == 610 hits P2, not a goal
    bus.ball_x = 10'd590;
    bus.p2_y   = 9'd100;
    repeat (8) tick_frame();
    tick_frame();
    chk("p2_hit", 32'(bus.h_col), 32'd1);
    chk("p2_no_goal", 32'(bus.p1_score), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
